camac_cycle_sequencer: RTL and testbench
========================================

Name: camac_cycle_sequencer

Overview:
Downstream stage of sm2201_interface_board. It takes one decoded CAMAC command (N, A, F, write data) per ISA I/O access and runs a single CAMAC dataway cycle: B, then S1, then S2. It captures read data, Q and X, and returns them with a response pulse. Its busy output drives isa_chrdy wait states in the ISA interface board.

Parameters:
T_SETUP, 2, isa_clk cycles with B/N/A/F valid before S1 (min 1)
T_S1, 2, S1 width in cycles (min 1)
T_GAP, 1, cycles between S1 falling and S2 rising (min 1)
T_S2, 2, S2 width in cycles (min 1)
T_HOLD, 1, cycles B/N/A/F held after S2 falls (min 1)

Ports:
isa_clk  in  1  ISA bus clock; all logic rises on this edge
isa_reset  in  1  asynchronous, active-high reset
req_valid  in  1  command request from ISA interface
req_ready  out  1  high only in IDLE; accept = req_valid && req_ready
req_init  in  1  1 = dataway Initialise (Z) cycle; N/A/F ignored
req_n  in  5  station number
req_a  in  4  subaddress
req_f  in  5  function code
req_wdata  in  24  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  24  captured read data; 0 for non-read F
rsp_q  out  1  captured Q
rsp_x  out  1  captured X
busy  out  1  high in every state except IDLE
cb_b  out  1  dataway Busy
cb_n  out  5  encoded station select; 0 when idle
cb_a  out  4  subaddress; 0 when idle
cb_f  out  5  function; 0 when idle
cb_s1  out  1  strobe 1
cb_s2  out  1  strobe 2
cb_z  out  1  Initialise
cb_w  out  24  write lines; 0 unless write cycle
cb_r  in  24  read lines
cb_q  in  1  Q response
cb_x  in  1  X response

Behaviour:
- All outputs are registered.
- Reset values: every output 0, except req_ready = 1. Reset sets state to IDLE.
- Reset in the middle of a cycle drops B, S1, S2, Z, N, A, F and W to 0 at once (asynchronous). No rsp_valid is produced for the aborted cycle.
- F classes:
  - read: F[4:3] = 00 (F0–F7)
  - write: F[4:3] = 10 (F16–F23)
  - anything else: control, no data transfer
- States: IDLE, SETUP, STROBE1, GAP, STROBE2, HOLD, RESP.
- IDLE:
  - On accept, latch the request and go to SETUP.
  - cb_b = 1 from SETUP through HOLD.
  - N/A/F are driven from the latched values during the same span.
  - cb_w = latched wdata during the same span for write F only.
- SETUP lasts T_SETUP cycles, then STROBE1.
- STROBE1: cb_s1 = 1 for T_SETUP..T_S1 cycles, i.e. T_S1 cycles. On the clock edge that ends STROBE1:
  - rsp_rdata <= cb_r if read, else 0
  - rsp_q <= cb_q
  - rsp_x <= cb_x
- GAP lasts T_GAP cycles.
- STROBE2: cb_s2 = 1 for T_S2 cycles.
- HOLD lasts T_HOLD cycles.
- RESP:
  - rsp_valid = 1 for exactly 1 cycle, with B low.
  - Then IDLE; req_ready is 1 on the following cycle.
- Init (req_init = 1):
  - cb_b = 1 and cb_z = 1 through SETUP..HOLD; N/A/F/W stay 0.
  - STROBE1 is skipped (SETUP goes to GAP); no S1 pulse.
  - S2 pulses normally.
  - rsp_q, rsp_x, rsp_rdata are reported as 0.
- Latency with defaults: accept at edge k gives B high in cycles k+1..k+8, S1 in k+3..k+4, S2 in k+6..k+7, rsp_valid in k+9. Init shortens this by T_S1.
- req_valid while busy is ignored and not queued; the ISA side holds the request.
- Phase counter loads (param − 1) and counts down; the state advances at 0. A parameter value of 1 gives one cycle.
- Response fields keep their values until the next capture.

Decomposition:
- Shared include sm2201_camac_defs.vh holds:
  - state encodings
  - F-class decode constants (F_READ_MASK, F_WRITE_MASK)
  - CAMAC bus widths (N = 5, A = 4, F = 5, data = 24)
- One sub-module, camac_phase_timer: a loadable down-counter with a done flag, 4-bit by default.

Test Plan:
- Reset: assert isa_reset mid-S1 (cycle k+3) → cb_b, cb_s1, cb_n drop in the same cycle; no rsp_valid; req_ready = 1 after release.
- Read N=5, A=2, F=0 with cb_r = 24'hA5A5A5, cb_q = 1, cb_x = 1 → S1 high in k+3..k+4, S2 high in k+6..k+7, rsp_valid at k+9 with rdata A5A5A5, q = 1, x = 1.
- Write N=3, A=0, F=16, wdata 24'h123456 → cb_w = 123456 in k+1..k+8, 0 otherwise; rsp_rdata = 0; cb_q = 0 gives rsp_q = 0.
- Control F=24, cb_x = 0 → cb_w stays 0; rsp_x = 0; cycle timing identical to read.
- Init request → cb_z and cb_b high for 6 cycles; no S1; S2 in k+4..k+5; rsp_valid at k+7.
- Back-to-back: req_valid held high across two commands → second accept at k+10; req_valid ignored during busy; exactly two rsp_valid pulses.

Source files
------------

// File: rtl/camac_cycle_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// camac_cycle_sequencer_pkg
// Shared definitions for the CAMAC dataway cycle sequencer:
//   - dataway field widths (N, A, F, data) and phase-timer width
//   - sequencer state encoding
//   - F-class decode constants and helper functions
// ---------------------------------------------------------------------------
package camac_cycle_sequencer_pkg;

    localparam int N_W    = 5;
    localparam int A_W    = 4;
    localparam int F_W    = 5;
    localparam int DATA_W = 24;
    localparam int PH_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE1 = 3'd2,
        ST_GAP     = 3'd3,
        ST_STROBE2 = 3'd4,
        ST_HOLD    = 3'd5,
        ST_RESP    = 3'd6
    } state_t;

    // F[4:3] selects the function class: 00 read (F0-F7), 10 write (F16-F23).
    localparam logic [F_W-1:0] F_CLASS_MASK = 5'b11000;
    localparam logic [F_W-1:0] F_READ_MASK  = 5'b00000;
    localparam logic [F_W-1:0] F_WRITE_MASK = 5'b10000;

    function automatic logic f_is_read(input logic [F_W-1:0] f);
        return (f & F_CLASS_MASK) == F_READ_MASK;
    endfunction

    function automatic logic f_is_write(input logic [F_W-1:0] f);
        return (f & F_CLASS_MASK) == F_WRITE_MASK;
    endfunction

endpackage

// File: rtl/camac_phase_timer.sv
// ---------------------------------------------------------------------------
// camac_phase_timer
// Loadable down-counter used to time each dataway phase. Loading (len - 1)
// gives a phase of len cycles; done is high while the count sits at zero.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load         load load_val this cycle
//   load_val     new count value
//   done         count has reached zero
// ---------------------------------------------------------------------------
module camac_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/camac_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// camac_cycle_sequencer
// Runs one CAMAC dataway cycle (B, S1, S2) per accepted command and returns
// captured read data, Q and X with a one-cycle response pulse.
// Ports:
//   isa_clk, isa_reset        clock, asynchronous active-high reset
//   req_valid/req_ready       command handshake (ready only in IDLE)
//   req_init                  Initialise (Z) cycle instead of N/A/F command
//   req_n/a/f, req_wdata      command fields
//   rsp_valid                 one-cycle response pulse
//   rsp_rdata, rsp_q, rsp_x   captured response, held until next capture
//   busy                      high whenever not IDLE (drives ISA wait states)
//   cb_*                      dataway outputs (B, N, A, F, S1, S2, Z, W)
//   cb_r, cb_q, cb_x          dataway inputs (read lines, Q, X)
// All outputs are registered.
// ---------------------------------------------------------------------------
module camac_cycle_sequencer
    import camac_cycle_sequencer_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_S1    = 2,
    parameter int T_GAP   = 1,
    parameter int T_S2    = 2,
    parameter int T_HOLD  = 1
) (
    input  logic              isa_clk,
    input  logic              isa_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_init,
    input  logic [N_W-1:0]    req_n,
    input  logic [A_W-1:0]    req_a,
    input  logic [F_W-1:0]    req_f,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_q,
    output logic              rsp_x,
    output logic              busy,
    output logic              cb_b,
    output logic [N_W-1:0]    cb_n,
    output logic [A_W-1:0]    cb_a,
    output logic [F_W-1:0]    cb_f,
    output logic              cb_s1,
    output logic              cb_s2,
    output logic              cb_z,
    output logic [DATA_W-1:0] cb_w,
    input  logic [DATA_W-1:0] cb_r,
    input  logic              cb_q,
    input  logic              cb_x
);

    state_t              state;
    state_t              state_nxt;

    logic                lat_init;
    logic [N_W-1:0]      lat_n;
    logic [A_W-1:0]      lat_a;
    logic [F_W-1:0]      lat_f;
    logic [DATA_W-1:0]   lat_w;

    logic                accept;
    logic                ph_done;
    logic                ph_load;
    logic [PH_W-1:0]     ph_load_val;

    // Command fields as they will be after this edge: the outputs are
    // registered, so the first SETUP cycle must already see the new request.
    logic                init_nxt;
    logic [N_W-1:0]      n_nxt;
    logic [A_W-1:0]      a_nxt;
    logic [F_W-1:0]      f_nxt;
    logic [DATA_W-1:0]   w_nxt;
    logic                bus_nxt;

    assign accept   = req_valid && req_ready;
    assign init_nxt = accept ? req_init  : lat_init;
    assign n_nxt    = accept ? req_n     : lat_n;
    assign a_nxt    = accept ? req_a     : lat_a;
    assign f_nxt    = accept ? req_f     : lat_f;
    assign w_nxt    = accept ? req_wdata : lat_w;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept)  state_nxt = ST_SETUP;
            ST_SETUP:   if (ph_done) state_nxt = lat_init ? ST_GAP : ST_STROBE1;
            ST_STROBE1: if (ph_done) state_nxt = ST_GAP;
            ST_GAP:     if (ph_done) state_nxt = ST_STROBE2;
            ST_STROBE2: if (ph_done) state_nxt = ST_HOLD;
            ST_HOLD:    if (ph_done) state_nxt = ST_RESP;
            ST_RESP:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_nxt = state_nxt inside {ST_SETUP, ST_STROBE1, ST_GAP, ST_STROBE2, ST_HOLD};
    end

    // The timer is reloaded on every state change with the length of the
    // phase being entered; IDLE and RESP do not use it.
    always_comb begin
        ph_load     = (state_nxt != state);
        ph_load_val = '0;
        case (state_nxt)
            ST_SETUP:   ph_load_val = PH_W'(T_SETUP - 1);
            ST_STROBE1: ph_load_val = PH_W'(T_S1 - 1);
            ST_GAP:     ph_load_val = PH_W'(T_GAP - 1);
            ST_STROBE2: ph_load_val = PH_W'(T_S2 - 1);
            ST_HOLD:    ph_load_val = PH_W'(T_HOLD - 1);
            default:    ph_load_val = '0;
        endcase
    end

    camac_phase_timer #(
        .W (PH_W)
    ) u_phase_timer (
        .clk      (isa_clk),
        .rst      (isa_reset),
        .load     (ph_load),
        .load_val (ph_load_val),
        .done     (ph_done)
    );

    always_ff @(posedge isa_clk or posedge isa_reset) begin
        if (isa_reset) begin
            state     <= ST_IDLE;
            lat_init  <= 1'b0;
            lat_n     <= '0;
            lat_a     <= '0;
            lat_f     <= '0;
            lat_w     <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_q     <= 1'b0;
            rsp_x     <= 1'b0;
            cb_b      <= 1'b0;
            cb_n      <= '0;
            cb_a      <= '0;
            cb_f      <= '0;
            cb_s1     <= 1'b0;
            cb_s2     <= 1'b0;
            cb_z      <= 1'b0;
            cb_w      <= '0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                lat_init <= req_init;
                lat_n    <= req_n;
                lat_a    <= req_a;
                lat_f    <= req_f;
                lat_w    <= req_wdata;
            end

            req_ready <= (state_nxt == ST_IDLE);
            busy      <= (state_nxt != ST_IDLE);
            rsp_valid <= (state_nxt == ST_RESP);

            // Initialise cycles assert Z with N/A/F/W forced to zero.
            cb_b  <= bus_nxt;
            cb_z  <= bus_nxt && init_nxt;
            cb_n  <= (bus_nxt && !init_nxt) ? n_nxt : '0;
            cb_a  <= (bus_nxt && !init_nxt) ? a_nxt : '0;
            cb_f  <= (bus_nxt && !init_nxt) ? f_nxt : '0;
            cb_w  <= (bus_nxt && !init_nxt && f_is_write(f_nxt)) ? w_nxt : '0;
            cb_s1 <= (state_nxt == ST_STROBE1);
            cb_s2 <= (state_nxt == ST_STROBE2);

            // Dataway responses are sampled at the end of S1; an Initialise
            // cycle has no S1 and reports zeros when it leaves SETUP.
            if (state == ST_STROBE1 && state_nxt == ST_GAP) begin
                rsp_rdata <= f_is_read(lat_f) ? cb_r : '0;
                rsp_q     <= cb_q;
                rsp_x     <= cb_x;
            end else if (state == ST_SETUP && state_nxt == ST_GAP) begin
                rsp_rdata <= '0;
                rsp_q     <= 1'b0;
                rsp_x     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_camac_cycle_sequencer.sv
module tb_camac_cycle_sequencer;

    logic        isa_clk;
    logic        isa_reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_init;
    logic [4:0]  req_n;
    logic [3:0]  req_a;
    logic [4:0]  req_f;
    logic [23:0] req_wdata;
    logic        rsp_valid;
    logic [23:0] rsp_rdata;
    logic        rsp_q;
    logic        rsp_x;
    logic        busy;
    logic        cb_b;
    logic [4:0]  cb_n;
    logic [3:0]  cb_a;
    logic [4:0]  cb_f;
    logic        cb_s1;
    logic        cb_s2;
    logic        cb_z;
    logic [23:0] cb_w;
    logic [23:0] cb_r;
    logic        cb_q;
    logic        cb_x;

    int checks;
    int failures;

    camac_cycle_sequencer dut (
        .isa_clk   (isa_clk),
        .isa_reset (isa_reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_init  (req_init),
        .req_n     (req_n),
        .req_a     (req_a),
        .req_f     (req_f),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_q     (rsp_q),
        .rsp_x     (rsp_x),
        .busy      (busy),
        .cb_b      (cb_b),
        .cb_n      (cb_n),
        .cb_a      (cb_a),
        .cb_f      (cb_f),
        .cb_s1     (cb_s1),
        .cb_s2     (cb_s2),
        .cb_z      (cb_z),
        .cb_w      (cb_w),
        .cb_r      (cb_r),
        .cb_q      (cb_q),
        .cb_x      (cb_x)
    );

    initial isa_clk = 1'b0;
    always #5 isa_clk = ~isa_clk;

    task automatic tick();
        @(posedge isa_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one command and checks cycles k+1 .. k+len+2 where k is the
    // accept edge. len = cycles with B high; response expected in k+len+1.
    task automatic run_cmd(input string name, input logic init, input logic [4:0] n,
                           input logic [3:0] a, input logic [4:0] f, input logic [23:0] w,
                           input logic [23:0] exp_w, input int len, input logic has_s1,
                           input int s2_lo, input logic [23:0] exp_rd, input logic exp_q,
                           input logic exp_x);
        logic e_b;
        check($sformatf("%s ready_before", name), 32'(req_ready), 32'd1);
        req_init  = init;
        req_n     = n;
        req_a     = a;
        req_f     = f;
        req_wdata = w;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int m = 1; m <= len + 2; m++) begin
            e_b = (m <= len);
            check($sformatf("%s c%0d cb_b", name, m), 32'(cb_b), 32'(e_b));
            check($sformatf("%s c%0d cb_z", name, m), 32'(cb_z), 32'(e_b && init));
            check($sformatf("%s c%0d cb_s1", name, m), 32'(cb_s1), 32'(has_s1 && m >= 3 && m <= 4));
            check($sformatf("%s c%0d cb_s2", name, m), 32'(cb_s2), 32'(m >= s2_lo && m <= s2_lo + 1));
            check($sformatf("%s c%0d cb_n", name, m), 32'(cb_n), (e_b && !init) ? 32'(n) : 32'd0);
            check($sformatf("%s c%0d cb_a", name, m), 32'(cb_a), (e_b && !init) ? 32'(a) : 32'd0);
            check($sformatf("%s c%0d cb_f", name, m), 32'(cb_f), (e_b && !init) ? 32'(f) : 32'd0);
            check($sformatf("%s c%0d cb_w", name, m), 32'(cb_w), e_b ? 32'(exp_w) : 32'd0);
            check($sformatf("%s c%0d rsp_valid", name, m), 32'(rsp_valid), 32'(m == len + 1));
            check($sformatf("%s c%0d busy", name, m), 32'(busy), 32'(m <= len + 1));
            check($sformatf("%s c%0d req_ready", name, m), 32'(req_ready), 32'(m >= len + 2));
            if (m >= len + 1) begin
                check($sformatf("%s c%0d rsp_rdata", name, m), 32'(rsp_rdata), 32'(exp_rd));
                check($sformatf("%s c%0d rsp_q", name, m), 32'(rsp_q), 32'(exp_q));
                check($sformatf("%s c%0d rsp_x", name, m), 32'(rsp_x), 32'(exp_x));
            end
            tick();
        end
    endtask

    initial begin
        int pulses;
        checks    = 0;
        failures  = 0;
        isa_reset = 1'b1;
        req_valid = 1'b0;
        req_init  = 1'b0;
        req_n     = '0;
        req_a     = '0;
        req_f     = '0;
        req_wdata = '0;
        cb_r      = '0;
        cb_q      = 1'b0;
        cb_x      = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst cb_b", 32'(cb_b), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst cb_w", 32'(cb_w), 32'd0);
        check("rst cb_z", 32'(cb_z), 32'd0);
        isa_reset = 1'b0;
        tick();
        check("post_rst req_ready", 32'(req_ready), 32'd1);

        // Reset asserted in the middle of S1 (cycle k+3)
        req_n     = 5'd9;
        req_a     = 4'd1;
        req_f     = 5'd0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("abort pre cb_s1", 32'(cb_s1), 32'd1);
        check("abort pre cb_n", 32'(cb_n), 32'd9);
        isa_reset = 1'b1;
        #1;
        check("abort cb_b", 32'(cb_b), 32'd0);
        check("abort cb_s1", 32'(cb_s1), 32'd0);
        check("abort cb_n", 32'(cb_n), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort req_ready", 32'(req_ready), 32'd1);
        tick();
        isa_reset = 1'b0;
        for (int m = 0; m < 10; m++) begin
            tick();
            check($sformatf("abort c%0d rsp_valid", m), 32'(rsp_valid), 32'd0);
            check($sformatf("abort c%0d busy", m), 32'(busy), 32'd0);
            check($sformatf("abort c%0d req_ready", m), 32'(req_ready), 32'd1);
        end

        // Read N=5 A=2 F=0
        cb_r = 24'hA5A5A5; cb_q = 1'b1; cb_x = 1'b1;
        run_cmd("read", 1'b0, 5'd5, 4'd2, 5'd0, 24'h777777, 24'h000000,
                8, 1'b1, 6, 24'hA5A5A5, 1'b1, 1'b1);

        // Write N=3 A=0 F=16
        cb_r = 24'hFFFFFF; cb_q = 1'b0; cb_x = 1'b1;
        run_cmd("write", 1'b0, 5'd3, 4'd0, 5'd16, 24'h123456, 24'h123456,
                8, 1'b1, 6, 24'h000000, 1'b0, 1'b1);

        // Control F=24
        cb_r = 24'h5A5A5A; cb_q = 1'b1; cb_x = 1'b0;
        run_cmd("ctrl", 1'b0, 5'd4, 4'd7, 5'd24, 24'hABCDEF, 24'h000000,
                8, 1'b1, 6, 24'h000000, 1'b1, 1'b0);

        // Initialise cycle: no S1, N/A/F/W held at zero, zero response
        cb_r = 24'h111111; cb_q = 1'b1; cb_x = 1'b1;
        run_cmd("init", 1'b1, 5'd7, 4'd3, 5'd16, 24'h222222, 24'h000000,
                6, 1'b0, 4, 24'h000000, 1'b0, 1'b0);

        // Back-to-back with req_valid held high
        cb_r      = 24'h0F0F0F; cb_q = 1'b1; cb_x = 1'b1;
        req_init  = 1'b0;
        req_n     = 5'd1;
        req_a     = 4'd1;
        req_f     = 5'd1;
        req_wdata = 24'h0;
        req_valid = 1'b1;
        pulses    = 0;
        tick();
        for (int m = 1; m <= 22; m++) begin
            if (rsp_valid) pulses++;
            if (m == 5)  check("b2b c5 cb_n", 32'(cb_n), 32'd1);
            if (m == 9)  check("b2b c9 rsp_valid", 32'(rsp_valid), 32'd1);
            if (m == 10) begin
                check("b2b c10 rsp_valid", 32'(rsp_valid), 32'd0);
                check("b2b c10 req_ready", 32'(req_ready), 32'd1);
                check("b2b c10 busy", 32'(busy), 32'd0);
            end
            if (m == 11) begin
                check("b2b c11 busy", 32'(busy), 32'd1);
                check("b2b c11 cb_n", 32'(cb_n), 32'd2);
                req_valid = 1'b0;
            end
            if (m == 15) check("b2b c15 req_ready", 32'(req_ready), 32'd0);
            if (m == 19) begin
                check("b2b c19 rsp_valid", 32'(rsp_valid), 32'd1);
                check("b2b c19 rsp_rdata", 32'(rsp_rdata), 32'h0F0F0F);
            end
            if (m == 5) req_n = 5'd2;
            tick();
        end
        check("b2b pulses", 32'(pulses), 32'd2);
        check("b2b final busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
